data_mmu: RTL and testbench
===========================

DATA_MMU -- requirements
Module: data_mmu

Interface
REQ-001 UTLB_EN, 1, enables the one-entry micro-TLB; 0 sends every mapped request to the TLB.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid_i  input  1  MEM stage translation request.
REQ-005 req_ready_o  output  1  block can accept a request this cycle.
REQ-006 req_vaddr_i  input  32  virtual address.
REQ-007 req_store_i  input  1  1 = store, 0 = load.
REQ-008 user_mode_i  input  1  current privilege is user.
REQ-009 asid_i  input  8  current EntryHi.ASID.
REQ-010 k0_i  input  3  Config.K0 cacheability for kseg0.
REQ-011 utlb_flush_i  input  1  TLBW or ASID write happened; invalidate micro-TLB.
REQ-012 data_tlbReq_o  output  1  TLB lookup strobe; TLB result is valid the following cycle.
REQ-013 data_vpn2_o  output  19  vaddr[31:13]; data_oddPage_o  output  1  vaddr[12]; data_asid_o  output  8  asid_i.
REQ-014 data_hit_i  input  1, data_pfn_i  input  20, data_c_i  input  3, data_d_i  input  1, data_v_i  input  1  TLB result.
REQ-015 resp_valid_o  output  1  response valid; resp_ready_i  input  1  consumer accepts.
REQ-016 resp_paddr_o  output  32, resp_cached_o  output  1, resp_exc_o  output  5 (ExcCode, 0 = none), resp_refill_o  output  1 (use refill vector).

Function
REQ-017 States IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-018 Accept = req_valid_i && req_ready_o; request fields registered on accept.
REQ-019 Region decode: kuseg (vaddr[31]=0) mapped; kseg0 (100) unmapped, paddr = {3'b000, vaddr[28:0]}, cached = (k0_i==3); kseg1 (101) unmapped, same paddr, uncached; kseg2/3 (11x) mapped.
REQ-020 user_mode_i && vaddr[31] on accept -> exc 4 (load) / 5 (store), refill 0, paddr 0, no TLB lookup.
REQ-021 Unmapped, address error, or micro-TLB hit: IDLE -> RESP next cycle (latency 1).
REQ-022 Mapped and micro-TLB miss: data_tlbReq_o asserted combinationally in the accept cycle with vpn2/odd/asid driven from current inputs; IDLE -> WAIT; WAIT samples TLB result and goes to RESP (latency 2).
REQ-023 data_tlbReq_o = 0 in every other cycle.
REQ-024 Mapped result rules, in priority: !hit -> exc 2/3 (load/store), refill 1; hit && !v -> exc 2/3, refill 0; store && !d -> exc 1 (Mod), refill 0; else exc 0, paddr = {pfn, vaddr[11:0]}, cached = (c==3).
REQ-025 Micro-TLB: one entry {valid, vpn2, odd, asid, pfn, c, d}; hit = valid && vpn2, odd, asid all equal to request; same REQ-024 rules apply to its data with v=1.
REQ-026 Fill micro-TLB in WAIT only when hit && v, and only if no flush arrived since the lookup accept cycle.
REQ-027 utlb_flush_i clears valid next edge; flush in the same cycle as an accept makes that request miss the micro-TLB.
REQ-028 RESP: outputs held stable while resp_valid_o && !resp_ready_i; RESP -> IDLE on resp_ready_i; no back-to-back accept in the same cycle (one bubble per request).
REQ-029 When not in RESP, resp_paddr_o, resp_cached_o, resp_exc_o and resp_refill_o are 0.

Reset
REQ-030 rst: state IDLE, resp_valid_o 0, all resp_* 0, data_tlbReq_o 0, micro-TLB valid 0; rst in WAIT or RESP drops the in-flight request with no response.

Verification
REQ-031 Kernel load 0x9FC0_1234, k0_i=3 -> resp next cycle, paddr 0x1FC0_1234, cached 1, exc 0, no tlbReq.
REQ-032 Load 0x0040_1008, asid 5, TLB hit pfn 0x12345, v=1, c=2 -> tlbReq in accept cycle with vpn2 0x00200, odd 1; resp 2 cycles later, paddr 0x1234_5008, cached 0; same address again -> latency 1, no tlbReq.
REQ-033 Store 0x0040_0000, TLB miss -> exc 3, refill 1; hit v=0 -> exc 3, refill 0; hit v=1 d=0 -> exc 1.
REQ-034 User-mode load 0x8000_0000 -> exc 4, no tlbReq; user-mode store -> exc 5.
REQ-035 Fill micro-TLB, pulse utlb_flush_i, repeat address -> tlbReq issued again; flush during WAIT -> no fill.
REQ-036 resp_ready_i held low 3 cycles -> outputs stable, req_ready_o 0; rst asserted in WAIT -> IDLE, resp_valid_o 0 next cycle.

Source files
------------

// File: rtl/data_mmu.sv
// data_mmu: MEM-stage data address translation with a one-entry micro-TLB.
// Unmapped, address-error and micro-TLB hits answer in 1 cycle; TLB lookups take 2.
module data_mmu #(
  parameter bit UTLB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_vaddr_i,
  input  logic        req_store_i,
  input  logic        user_mode_i,
  input  logic [7:0]  asid_i,
  input  logic [2:0]  k0_i,
  input  logic        utlb_flush_i,
  output logic        data_tlbReq_o,
  output logic [18:0] data_vpn2_o,
  output logic        data_oddPage_o,
  output logic [7:0]  data_asid_o,
  input  logic        data_hit_i,
  input  logic [19:0] data_pfn_i,
  input  logic [2:0]  data_c_i,
  input  logic        data_d_i,
  input  logic        data_v_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_paddr_o,
  output logic        resp_cached_o,
  output logic [4:0]  resp_exc_o,
  output logic        resp_refill_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] va_q, va_d;
  logic        st_q, st_d;
  logic [7:0]  asid_q, asid_d;
  logic        fl_q, fl_d;
  logic        ut_v_q, ut_v_d;
  logic [18:0] ut_vpn2_q, ut_vpn2_d;
  logic        ut_odd_q, ut_odd_d;
  logic [7:0]  ut_asid_q, ut_asid_d;
  logic [19:0] ut_pfn_q, ut_pfn_d;
  logic [2:0]  ut_c_q, ut_c_d;
  logic        ut_dty_q, ut_dty_d;
  // {exc, refill, cached, paddr}
  logic [38:0] res_q, res_d;

  logic        accept;
  logic        adr_err;
  logic        unmapped;
  logic        ut_hit;
  logic [38:0] ut_res;
  logic [38:0] tlb_res;

  function automatic logic [38:0] map_res(
    input logic        hit,
    input logic        v,
    input logic        d,
    input logic [2:0]  c,
    input logic [19:0] pfn,
    input logic        store,
    input logic [11:0] off
  );
    logic [4:0] ec;
    ec = store ? 5'd3 : 5'd2;
    priority case (1'b1)
      !hit:       map_res = {ec, 1'b1, 1'b0, 32'd0};
      !v:         map_res = {ec, 1'b0, 1'b0, 32'd0};
      store && !d: map_res = {5'd1, 1'b0, 1'b0, 32'd0};
      default:    map_res = {5'd0, 1'b0, c == 3'd3, pfn, off};
    endcase
  endfunction

  assign req_ready_o = state_q == IDLE;
  assign accept      = req_valid_i && req_ready_o;
  assign adr_err     = user_mode_i && req_vaddr_i[31];
  assign unmapped    = req_vaddr_i[31:30] == 2'b10;

  // A flush in the accept cycle already counts against the entry.
  assign ut_hit = UTLB_EN && ut_v_q && !utlb_flush_i &&
                  ut_vpn2_q == req_vaddr_i[31:13] &&
                  ut_odd_q == req_vaddr_i[12] &&
                  ut_asid_q == asid_i;

  assign data_tlbReq_o  = accept && !adr_err && !unmapped && !ut_hit;
  assign data_vpn2_o    = req_vaddr_i[31:13];
  assign data_oddPage_o = req_vaddr_i[12];
  assign data_asid_o    = asid_i;

  assign ut_res  = map_res(1'b1, 1'b1, ut_dty_q, ut_c_q, ut_pfn_q,
                           req_store_i, req_vaddr_i[11:0]);
  assign tlb_res = map_res(data_hit_i, data_v_i, data_d_i, data_c_i,
                           data_pfn_i, st_q, va_q[11:0]);

  always_comb begin
    state_d   = state_q;
    va_d      = va_q;
    st_d      = st_q;
    asid_d    = asid_q;
    fl_d      = fl_q | utlb_flush_i;
    ut_v_d    = ut_v_q && !utlb_flush_i;
    ut_vpn2_d = ut_vpn2_q;
    ut_odd_d  = ut_odd_q;
    ut_asid_d = ut_asid_q;
    ut_pfn_d  = ut_pfn_q;
    ut_c_d    = ut_c_q;
    ut_dty_d  = ut_dty_q;
    res_d     = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          va_d    = req_vaddr_i;
          st_d    = req_store_i;
          asid_d  = asid_i;
          fl_d    = utlb_flush_i;
          state_d = RESP;
          priority case (1'b1)
            adr_err:  res_d = {req_store_i ? 5'd5 : 5'd4, 34'd0};
            unmapped: res_d = {5'd0, 1'b0,
                               !req_vaddr_i[29] && k0_i == 3'd3,
                               3'b000, req_vaddr_i[28:0]};
            ut_hit:   res_d = ut_res;
            default:  state_d = WAIT;
          endcase
        end
      end
      WAIT: begin
        res_d   = tlb_res;
        state_d = RESP;
        if (data_hit_i && data_v_i && !fl_q && !utlb_flush_i) begin
          ut_v_d    = 1'b1;
          ut_vpn2_d = va_q[31:13];
          ut_odd_d  = va_q[12];
          ut_asid_d = asid_q;
          ut_pfn_d  = data_pfn_i;
          ut_c_d    = data_c_i;
          ut_dty_d  = data_d_i;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          res_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        res_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      va_q      <= '0;
      st_q      <= 1'b0;
      asid_q    <= '0;
      fl_q      <= 1'b0;
      ut_v_q    <= 1'b0;
      ut_vpn2_q <= '0;
      ut_odd_q  <= 1'b0;
      ut_asid_q <= '0;
      ut_pfn_q  <= '0;
      ut_c_q    <= '0;
      ut_dty_q  <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      va_q      <= va_d;
      st_q      <= st_d;
      asid_q    <= asid_d;
      fl_q      <= fl_d;
      ut_v_q    <= ut_v_d;
      ut_vpn2_q <= ut_vpn2_d;
      ut_odd_q  <= ut_odd_d;
      ut_asid_q <= ut_asid_d;
      ut_pfn_q  <= ut_pfn_d;
      ut_c_q    <= ut_c_d;
      ut_dty_q  <= ut_dty_d;
      res_q     <= res_d;
    end
  end

  assign resp_valid_o  = state_q == RESP;
  assign resp_exc_o    = res_q[38:34];
  assign resp_refill_o = res_q[33];
  assign resp_cached_o = res_q[32];
  assign resp_paddr_o  = res_q[31:0];

endmodule

// File: tb/tb_data_mmu.sv
// tb_data_mmu: randomized scoreboard bench for data_mmu.
// A page-table/micro-TLB reference model predicts each response.
module tb_data_mmu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i = '0;
  logic        req_store_i = 1'b0;
  logic        user_mode_i = 1'b0;
  logic [7:0]  asid_i = '0;
  logic [2:0]  k0_i = '0;
  logic        utlb_flush_i = 1'b0;
  logic        data_tlbReq_o;
  logic [18:0] data_vpn2_o;
  logic        data_oddPage_o;
  logic [7:0]  data_asid_o;
  logic        data_hit_i = 1'b0;
  logic [19:0] data_pfn_i = '0;
  logic [2:0]  data_c_i = '0;
  logic        data_d_i = 1'b0;
  logic        data_v_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_paddr_o;
  logic        resp_cached_o;
  logic [4:0]  resp_exc_o;
  logic        resp_refill_o;

  always #5 clk = ~clk;

  data_mmu dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vaddr_i(req_vaddr_i), .req_store_i(req_store_i),
    .user_mode_i(user_mode_i), .asid_i(asid_i), .k0_i(k0_i),
    .utlb_flush_i(utlb_flush_i),
    .data_tlbReq_o(data_tlbReq_o), .data_vpn2_o(data_vpn2_o),
    .data_oddPage_o(data_oddPage_o), .data_asid_o(data_asid_o),
    .data_hit_i(data_hit_i), .data_pfn_i(data_pfn_i),
    .data_c_i(data_c_i), .data_d_i(data_d_i), .data_v_i(data_v_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_paddr_o(resp_paddr_o), .resp_cached_o(resp_cached_o),
    .resp_exc_o(resp_exc_o), .resp_refill_o(resp_refill_o)
  );

  typedef struct {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } pte_t;

  typedef struct {
    logic [4:0]  exc;
    logic        refill;
    logic        cached;
    logic [31:0] paddr;
    bit          chk_pa;
    bit          chk_c;
    int          acc;
    int          lat;
  } exp_t;

  pte_t tbl [bit [27:0]];
  exp_t sbq [$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  bit          m_valid = 1'b0;
  bit   [27:0] m_key   = '0;
  pte_t        m_pte;

  bit rdy_low = 1'b0;

  logic [18:0] pool [4] = '{19'h00010, 19'h00200, 19'h60000, 19'h7FFFF};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Joint-TLB stand-in: answers the cycle after a lookup strobe.
  bit        t_pend;
  bit [27:0] t_key;
  always @(posedge clk) begin
    t_pend = data_tlbReq_o;
    t_key  = {data_asid_o, data_vpn2_o, data_oddPage_o};
    #1;
    if (t_pend && tbl.exists(t_key)) begin
      data_hit_i = 1'b1;
      data_pfn_i = tbl[t_key].pfn;
      data_c_i   = tbl[t_key].c;
      data_d_i   = tbl[t_key].d;
      data_v_i   = tbl[t_key].v;
    end else begin
      data_hit_i = t_pend ? 1'b0 : 1'($urandom_range(1));
      data_pfn_i = 20'($urandom);
      data_c_i   = 3'($urandom_range(7));
      data_d_i   = 1'($urandom_range(1));
      data_v_i   = 1'($urandom_range(1));
    end
  end

  always @(posedge clk) begin
    #2;
    resp_ready_i = rdy_low ? 1'b0 : ($urandom_range(3) != 0);
  end

  // Monitor: pops one expectation per response and checks it is held.
  bit          seen = 1'b0;
  logic [38:0] held;
  logic [38:0] cur;
  exp_t        me;
  always @(negedge clk) begin
    cur = {resp_exc_o, resp_refill_o, resp_cached_o, resp_paddr_o};
    if (rst) begin
      seen = 1'b0;
    end else if (resp_valid_o) begin
      if (!seen) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid_o), 64'(0));
        end else begin
          me = sbq.pop_front();
          chk("latency", 64'(cyc - me.acc), 64'(me.lat));
          chk("exc", 64'(resp_exc_o), 64'(me.exc));
          chk("refill", 64'(resp_refill_o), 64'(me.refill));
          if (me.chk_pa) chk("paddr", 64'(resp_paddr_o), 64'(me.paddr));
          if (me.chk_c) chk("cached", 64'(resp_cached_o), 64'(me.cached));
        end
        held = cur;
        seen = 1'b1;
      end else begin
        chk("resp_hold", 64'(cur), 64'(held));
      end
      if (resp_ready_i) seen = 1'b0;
    end else begin
      chk("idle_resp_zero", 64'(cur), 64'(0));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) chk("ready_timeout", 64'(req_ready_o), 64'(1));
  endtask

  task automatic flush_pulse();
    utlb_flush_i = 1'b1;
    @(negedge clk);
    utlb_flush_i = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] va, input logic st,
                       input logic um, input logic [7:0] asid,
                       input logic [2:0] k0, input bit fa, input bit fw);
    exp_t      e;
    bit [27:0] key;
    bit        ae, unm, uh, treq, hit, fill;
    pte_t      p;
    wait_idle();
    key  = {asid, va[31:13], va[12]};
    ae   = um && va[31];
    unm  = va[31:30] == 2'b10;
    uh   = !ae && !unm && m_valid && !fa && m_key == key;
    treq = !ae && !unm && !uh;
    e    = '{default: 0};
    e.lat = treq ? 2 : 1;
    fill = 1'b0;
    p    = '{default: 0};
    if (ae) begin
      e.exc = st ? 5'd5 : 5'd4;
    end else if (unm) begin
      e.paddr  = {3'b000, va[28:0]};
      e.cached = !va[29] && k0 == 3'd3;
    end else begin
      hit = 1'b1;
      if (uh) begin
        p   = m_pte;
        p.v = 1'b1;
      end else if (tbl.exists(key)) begin
        p = tbl[key];
      end else begin
        hit = 1'b0;
      end
      if (!hit) begin
        e.exc    = st ? 5'd3 : 5'd2;
        e.refill = 1'b1;
      end else if (!p.v) begin
        e.exc = st ? 5'd3 : 5'd2;
      end else if (st && !p.d) begin
        e.exc = 5'd1;
      end else begin
        e.paddr  = {p.pfn, va[11:0]};
        e.cached = p.c == 3'd3;
      end
      fill = treq && hit && p.v && !fa && !fw;
    end
    e.chk_pa = ae || e.exc == 5'd0;
    e.chk_c  = e.exc == 5'd0;
    if (fa || (fw && treq)) m_valid = 1'b0;
    if (fill) begin
      m_valid = 1'b1;
      m_key   = key;
      m_pte   = p;
    end
    req_valid_i  = 1'b1;
    req_vaddr_i  = va;
    req_store_i  = st;
    user_mode_i  = um;
    asid_i       = asid;
    k0_i         = k0;
    utlb_flush_i = fa;
    #1;
    chk("tlbreq", 64'(data_tlbReq_o), 64'(treq));
    if (treq)
      chk("lookup_key", 64'({data_asid_o, data_vpn2_o, data_oddPage_o}),
          64'(key));
    e.acc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    req_valid_i  = 1'b0;
    utlb_flush_i = fw && treq;
    @(negedge clk);
    utlb_flush_i = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 2; o++)
        for (int i = 0; i < 4; i++)
          if ($urandom_range(3) != 0)
            tbl[{8'(a), pool[i], 1'(o)}] = '{pfn: 20'($urandom),
              c: 3'($urandom_range(7)), d: 1'($urandom_range(1)),
              v: $urandom_range(4) != 0};

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    chk("rst_req_ready", 64'(req_ready_o), 64'(1));
    chk("rst_tlbreq", 64'(data_tlbReq_o), 64'(0));
    chk("rst_resp_fields",
        64'({resp_exc_o, resp_refill_o, resp_cached_o, resp_paddr_o}),
        64'(0));
    rst = 1'b0;
    @(negedge clk);

    // kseg0, cached via K0
    issue(32'h9FC0_1234, 1'b0, 1'b0, 8'd0, 3'd3, 1'b0, 1'b0);
    // kseg1 uncached
    issue(32'hBFC0_0010, 1'b1, 1'b0, 8'd0, 3'd3, 1'b0, 1'b0);

    tbl[{8'd5, 19'h00200, 1'b1}] =
      '{pfn: 20'h12345, c: 3'd2, d: 1'b1, v: 1'b1};
    issue(32'h0040_1008, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0);
    issue(32'h0040_1008, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0);

    issue(32'h0040_0000, 1'b1, 1'b0, 8'd7, 3'd0, 1'b0, 1'b0);
    tbl[{8'd7, 19'h00200, 1'b0}] = '{pfn: 20'h00ABC, c: 3'd3, d: 1'b0, v: 1'b0};
    issue(32'h0040_0000, 1'b1, 1'b0, 8'd7, 3'd0, 1'b0, 1'b0);
    tbl[{8'd7, 19'h00200, 1'b0}].v = 1'b1;
    issue(32'h0040_0000, 1'b1, 1'b0, 8'd7, 3'd0, 1'b0, 1'b0);
    issue(32'h0040_0004, 1'b0, 1'b0, 8'd7, 3'd0, 1'b0, 1'b0);

    issue(32'h8000_0000, 1'b0, 1'b1, 8'd0, 3'd3, 1'b0, 1'b0);
    issue(32'h8000_0000, 1'b1, 1'b1, 8'd0, 3'd3, 1'b0, 1'b0);

    // flush after fill, flush during lookup, flush at accept
    issue(32'h0040_1008, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0);
    wait_idle();
    flush_pulse();
    issue(32'h0040_1008, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b1);
    issue(32'h0040_1008, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0);
    issue(32'h0040_1008, 1'b0, 1'b0, 8'd5, 3'd0, 1'b1, 1'b0);
    issue(32'h0040_1008, 1'b0, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0);
    issue(32'h0040_1010, 1'b1, 1'b0, 8'd5, 3'd0, 1'b0, 1'b0);

    // consumer stalls for 3 cycles
    wait_idle();
    rdy_low = 1'b1;
    issue(32'hA000_0040, 1'b0, 1'b0, 8'd0, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(resp_valid_o), 64'(1));
      chk("stall_ready", 64'(req_ready_o), 64'(0));
      @(negedge clk);
    end
    rdy_low = 1'b0;

    // reset while waiting on the TLB drops the request
    wait_idle();
    req_valid_i = 1'b1;
    req_vaddr_i = 32'h0040_2000;
    req_store_i = 1'b0;
    user_mode_i = 1'b0;
    asid_i      = 8'd9;
    #1;
    chk("rstwait_tlbreq", 64'(data_tlbReq_o), 64'(1));
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rstwait_in_wait", 64'(req_ready_o), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    chk("rstwait_valid", 64'(resp_valid_o), 64'(0));
    chk("rstwait_ready", 64'(req_ready_o), 64'(1));

    for (int n = 0; n < 300; n++) begin
      logic [31:0] va;
      int r;
      r = $urandom_range(9);
      if (r < 6)
        va = {pool[$urandom_range(3)], 1'($urandom_range(1)), 12'($urandom)};
      else if (r < 8)
        va = {2'b10, 30'($urandom)};
      else
        va = $urandom;
      if ($urandom_range(15) == 0) begin
        wait_idle();
        flush_pulse();
      end
      issue(va, 1'($urandom_range(1)), $urandom_range(4) == 0,
            8'($urandom_range(2)), 3'($urandom_range(7)),
            $urandom_range(9) == 0, $urandom_range(9) == 0);
    end

    for (int n = 0; n < 200 && (sbq.size() != 0 || resp_valid_o); n++)
      @(negedge clk);
    if (sbq.size() != 0) chk("drain", 64'(sbq.size()), 64'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
